// File: rtl/data_cache_dm_if.sv
// Core-side and memory-side signal bundle for the direct-mapped data cache.
// The cache takes the slave view; the core/memory environment takes the master view.
interface data_cache_dm_if;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic         proc_stall;
    logic [31:0]  proc_rdata;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_ready;
    logic [127:0] mem_rdata;

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata, mem_ready, mem_rdata,
        output proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata, mem_ready, mem_rdata,
        input  proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/data_cache_dm.sv
// Direct-mapped, write-back, write-allocate data cache with 4-word lines.
// Hits complete combinationally in IDLE; misses go through WRITEBACK and/or ALLOCATE.
module data_cache_dm #(
    parameter int NUM_SETS = 8
) (
    input  logic            clk,
    input  logic            proc_reset,
    data_cache_dm_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = 28 - IDX_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

    state_t              state_q;
    logic [NUM_SETS-1:0] valid_q;
    logic [NUM_SETS-1:0] dirty_q;
    logic [TAG_W-1:0]    tag_q  [NUM_SETS];
    logic [127:0]        data_q [NUM_SETS];

    logic                mem_read_q;
    logic                mem_write_q;
    logic [27:0]         mem_addr_q;
    logic [127:0]        mem_wdata_q;

    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    tag;
    logic [1:0]          off;
    logic                req;
    logic                is_write;
    logic                hit;
    logic [127:0]        line;
    logic [31:0]         line_words [4];
    logic [31:0]         word;

    assign idx      = bus.proc_addr[IDX_W+1:2];
    assign tag      = bus.proc_addr[29:IDX_W+2];
    assign off      = bus.proc_addr[1:0];
    assign req      = bus.proc_read | bus.proc_write;
    // A simultaneous read and write is handled as a write.
    assign is_write = bus.proc_write;
    assign line     = data_q[idx];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_word
            assign line_words[gi] = line[gi*32 +: 32];
        end
    endgenerate

    assign word = line_words[off];
    assign hit  = (state_q == IDLE) && req && valid_q[idx] && (tag_q[idx] == tag);

    assign bus.proc_stall = (state_q != IDLE) || (req && !hit);
    assign bus.proc_rdata = (hit && !is_write) ? word : 32'h0;
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;

    // Control state and line status; memory-side outputs are registered so they
    // drop immediately on reset and never overlap.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req && !hit) begin
                        if (valid_q[idx] && dirty_q[idx]) begin
                            state_q     <= WRITEBACK;
                            mem_write_q <= 1'b1;
                            mem_addr_q  <= {tag_q[idx], idx};
                            mem_wdata_q <= line;
                        end else begin
                            state_q    <= ALLOCATE;
                            mem_read_q <= 1'b1;
                            mem_addr_q <= {tag, idx};
                        end
                    end else if (hit && is_write) begin
                        dirty_q[idx] <= 1'b1;
                    end
                end
                WRITEBACK: begin
                    if (bus.mem_ready) begin
                        state_q     <= ALLOCATE;
                        mem_write_q <= 1'b0;
                        mem_read_q  <= 1'b1;
                        mem_addr_q  <= {tag, idx};
                    end
                end
                ALLOCATE: begin
                    if (bus.mem_ready) begin
                        state_q      <= IDLE;
                        mem_read_q   <= 1'b0;
                        valid_q[idx] <= 1'b1;
                        dirty_q[idx] <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                end
            endcase
        end
    end

    // Line storage carries no reset; the valid bits qualify its contents.
    always_ff @(posedge clk) begin
        if (hit && is_write) begin
            data_q[idx][{off, 5'b0} +: 32] <= bus.proc_wdata;
        end else if (state_q == ALLOCATE && bus.mem_ready) begin
            data_q[idx] <= bus.mem_rdata;
            tag_q[idx]  <= tag;
        end
    end
endmodule
